uart_rx_gen2: RTL and testbench
===============================

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the maximum data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PRESCALE_W, default 6, meaning the width of the prescale input.
REQ-003 Port CLK  input  1  receiver oversampling clock; the block SHALL use this single clock.
REQ-004 Port RST  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 Port S_RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-006 Port PAR_EN  input  1  parity bit present when 1.
REQ-007 Port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port STOP2  input  1  two stop bits when 1, one when 0.
REQ-009 Port DATA_LEN  input  4  data bits per frame (5..DATA_WIDTH).
REQ-010 Port prescale  input  PRESCALE_W  CLK cycles per bit (8, 16 or 32).
REQ-011 Port P_DATA  output  DATA_WIDTH  received word, LSB-first assembled, right-aligned.
REQ-012 Port Data_Valid  output  1  one-cycle pulse marking a good frame on P_DATA.
REQ-013 Ports par_err, stp_err, start_glitch  output  1 each  one-cycle error pulses.

Function
REQ-014 S_RX_IN SHALL pass through a 2-flop synchronizer before any use, adding 2 CLK of latency.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with transitions IDLE->START on synchronized line low, START->DATA, DATA->PARITY (PAR_EN) or ->STOP, PARITY->STOP, and STOP->IDLE.
REQ-016 PAR_EN, PAR_TYP, STOP2, DATA_LEN and prescale SHALL be latched on IDLE->START, and changes mid-frame SHALL be ignored.
REQ-017 A latched prescale other than 8/16/32 SHALL be treated as 16; DATA_LEN below 5 SHALL be treated as 5; DATA_LEN above DATA_WIDTH SHALL be treated as DATA_WIDTH.
REQ-018 Per bit, an edge counter SHALL run 0..prescale-1 and then wrap, and a bit counter SHALL advance on wrap.
REQ-019 Each bit value SHALL be the majority of the samples at edge counts prescale/2-1, prescale/2 and prescale/2+1, available from edge count prescale/2+2 onward.
REQ-020 If the sampled start bit is 1, start_glitch SHALL pulse for one cycle and the FSM SHALL return to IDLE at the end of the start bit, with no other output change.
REQ-021 Data bits SHALL be shifted LSB first, and P_DATA bits at or above the latched DATA_LEN SHALL be 0.
REQ-022 The parity check SHALL XOR the data bits with PAR_TYP and compare the result to the sampled parity bit.
REQ-023 Every stop bit SHALL sample as 1, otherwise the frame has a stop error; with STOP2, both stop bits SHALL be checked.
REQ-024 At the final stop bit's edge count prescale-1, exactly one outcome SHALL be registered: Data_Valid=1 with P_DATA updated, or par_err and/or stp_err=1 with P_DATA unchanged.
REQ-025 When both errors occur, par_err and stp_err SHALL pulse in the same cycle.
REQ-026 P_DATA SHALL hold its value until the next good frame.
REQ-027 The FSM SHALL enter IDLE in the cycle after the final stop bit, and a line low then SHALL start a new frame immediately (back-to-back frames with zero idle).
REQ-028 A break (line low through all stop bits) SHALL report stp_err only, and the FSM SHALL then wait in IDLE for the line to return high before accepting a new start.
REQ-029 Counter widths SHALL be sized from PRESCALE_W and DATA_WIDTH+4 with no overflow at prescale=32 and a 13-bit frame.

Reset
REQ-030 On RST low, the FSM SHALL go to IDLE and all counters and synchronizer flops SHALL go to 1/idle.
REQ-031 On RST low, P_DATA SHALL be 0 and Data_Valid, par_err, stp_err and start_glitch SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-033 After RST releases, reception SHALL resume only on a new start bit.

Structure
REQ-034 Package uart_rx_pkg SHALL hold the FSM state enum, the legal prescale constants (8, 16, 32), the default prescale (16) and the majority-of-3 function.
REQ-035 Sub-module uart_rx_sampler SHALL contain the synchronizer, edge counter and majority voter, outputting the sampled bit plus a sample-valid strobe; the FSM, shift register and checks SHALL remain in the top.

Verification
REQ-036 prescale=16, 8N1, byte 0xA5 -> Data_Valid pulses once, P_DATA=0xA5, and no error pulses.
REQ-037 prescale=8, DATA_LEN=7, even parity, STOP2, data 0x55 with parity bit forced to 1 -> par_err pulses once, Data_Valid=0 and P_DATA keeps its old value.
REQ-038 A low pulse of 3 CLK at prescale=16 while idle -> start_glitch pulses, with no Data_Valid and no errors.
REQ-039 Two back-to-back frames 0x00 then 0xFF at prescale=32, 9-bit DATA_WIDTH with DATA_LEN=9, odd parity -> two Data_Valid pulses with P_DATA=0x000 then 0x1FF.
REQ-040 A single-sample glitch inside a data bit's centre window -> it is voted out and P_DATA is correct.
REQ-041 RST asserted in the DATA state of frame 0x3C, then frame 0xC3 -> no pulse for the first frame, and Data_Valid with P_DATA=0xC3 for the second.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Latency: not applicable (declarations only); backpressure: none.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PRESC_8   = 8;
    localparam int PRESC_16  = 16;
    localparam int PRESC_32  = 32;
    localparam int PRESC_DEF = PRESC_16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_gen2_if.sv
// Serial line, frame config and result pulses of the UART receiver.
// Latency: none (wires only); backpressure: none, results are fire-and-forget pulses.
interface uart_rx_gen2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  S_RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [3:0]            DATA_LEN;
    logic [PRESCALE_W-1:0] prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  start_glitch;

    modport master (
        output S_RX_IN, PAR_EN, PAR_TYP, STOP2, DATA_LEN, prescale,
        input  P_DATA, Data_Valid, par_err, stp_err, start_glitch
    );

    modport slave (
        input  S_RX_IN, PAR_EN, PAR_TYP, STOP2, DATA_LEN, prescale,
        output P_DATA, Data_Valid, par_err, stp_err, start_glitch
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority voter.
// Latency: 2 CLK sync, vote ready at count presc/2+2; backpressure: none.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic                  cnt_en,
    input  logic [PRESCALE_W-1:0] presc,
    output logic                  line_s,
    output logic                  bit_end,
    output logic                  smp_bit,
    output logic                  smp_vld
);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  bit_q, bit_d, vld_q, vld_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d, half;

    assign half    = presc >> 1;
    assign bit_end = cnt_en && (cnt_q == presc - ONE);
    assign line_s  = sync2_q;
    assign smp_bit = bit_q;
    assign smp_vld = vld_q;

    always_comb begin
        sync1_d = rx_in;
        sync2_d = sync1_q;
        cnt_d   = '0;
        s0_d    = s0_q;
        s1_d    = s1_q;
        bit_d   = bit_q;
        vld_d   = 1'b0;
        if (cnt_en) begin
            cnt_d = bit_end ? '0 : cnt_q + ONE;
            if (cnt_q == half - ONE) s0_d = sync2_q;
            if (cnt_q == half)       s1_d = sync2_q;
            // third sample is taken live and voted in the same cycle
            if (cnt_q == half + ONE) begin
                bit_d = maj3(s0_q, s1_q, sync2_q);
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            bit_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            bit_q   <= bit_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: rtl/uart_rx_gen2.sv
// UART receiver: frame FSM, LSB-first assembly, parity/stop checks, result pulses.
// Latency: result 1 CLK after last stop bit ends (+2 CLK sync); backpressure: none.
module uart_rx_gen2
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_gen2_if.slave bus
);
    localparam int         BCW     = $clog2(DATA_WIDTH + 4);
    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, pdata_q, pdata_d;
    logic                  par_bit_q, par_bit_d, stp_ok_q, stp_ok_d;
    logic                  all_low_q, all_low_d, brk_q, brk_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic [3:0]            len_q, len_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  dv_q, dv_d, perr_q, perr_d, serr_q, serr_d, gl_q, gl_d;

    logic line_s, bit_end, smp_bit, smp_vld;
    logic start_go, cnt_en, brk_now, stp_bad, par_bad;

    // after a break the line must return high before a new start counts
    assign start_go = (state_q == IDLE) && !line_s && !brk_q;
    assign cnt_en   = (state_q != IDLE) || start_go;
    assign brk_now  = all_low_q && !smp_bit;
    assign stp_bad  = !(stp_ok_q && smp_bit);
    assign par_bad  = par_en_q && ((^sh_q ^ par_typ_q) != par_bit_q) && !brk_now;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK     (CLK),
        .RST     (RST),
        .rx_in   (bus.S_RX_IN),
        .cnt_en  (cnt_en),
        .presc   (presc_q),
        .line_s  (line_s),
        .bit_end (bit_end),
        .smp_bit (smp_bit),
        .smp_vld (smp_vld)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        pdata_d   = pdata_q;
        par_bit_d = par_bit_q;
        stp_ok_d  = stp_ok_q;
        all_low_d = all_low_q;
        brk_d     = brk_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        len_d     = len_q;
        presc_d   = presc_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        gl_d      = 1'b0;
        if (bit_end && smp_bit) all_low_d = 1'b0;
        if (brk_q && line_s)    brk_d     = 1'b0;
        case (state_q)
            IDLE: if (start_go) begin
                state_d   = START;
                all_low_d = 1'b1;
                par_en_d  = bus.PAR_EN;
                par_typ_d = bus.PAR_TYP;
                stop2_d   = bus.STOP2;
                if (bus.DATA_LEN < LEN_MIN)      len_d = LEN_MIN;
                else if (bus.DATA_LEN > LEN_MAX) len_d = LEN_MAX;
                else                             len_d = bus.DATA_LEN;
                if (bus.prescale == PRESCALE_W'(PRESC_8) ||
                    bus.prescale == PRESCALE_W'(PRESC_16) ||
                    bus.prescale == PRESCALE_W'(PRESC_32))
                    presc_d = bus.prescale;
                else
                    presc_d = PRESCALE_W'(PRESC_DEF);
            end
            START: begin
                if (smp_vld && smp_bit) gl_d = 1'b1;
                if (bit_end) begin
                    state_d   = smp_bit ? IDLE : DATA;
                    bit_cnt_d = '0;
                    sh_d      = '0;
                    stp_ok_d  = 1'b1;
                end
            end
            DATA: if (bit_end) begin
                sh_d      = sh_q | (DATA_WIDTH'(smp_bit) << bit_cnt_q);
                bit_cnt_d = bit_cnt_q + BCW'(1);
                if (bit_cnt_q == BCW'(len_q - 4'd1)) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) begin
                par_bit_d = smp_bit;
                state_d   = STOP;
            end
            STOP: if (bit_end) begin
                if (stop2_q && bit_cnt_q == '0) begin
                    stp_ok_d  = stp_ok_q & smp_bit;
                    bit_cnt_d = BCW'(1);
                end else begin
                    state_d = IDLE;
                    if (!stp_bad && !par_bad) begin
                        dv_d    = 1'b1;
                        pdata_d = sh_q;
                    end else begin
                        perr_d = par_bad;
                        serr_d = stp_bad;
                    end
                    if (brk_now) brk_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            pdata_q   <= '0;
            par_bit_q <= 1'b0;
            stp_ok_q  <= 1'b1;
            all_low_q <= 1'b0;
            brk_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            len_q     <= LEN_MAX;
            presc_q   <= PRESCALE_W'(PRESC_DEF);
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            gl_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            pdata_q   <= pdata_d;
            par_bit_q <= par_bit_d;
            stp_ok_q  <= stp_ok_d;
            all_low_q <= all_low_d;
            brk_q     <= brk_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            len_q     <= len_d;
            presc_q   <= presc_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            gl_q      <= gl_d;
        end
    end

    assign bus.P_DATA       = pdata_q;
    assign bus.Data_Valid   = dv_q;
    assign bus.par_err      = perr_q;
    assign bus.stp_err      = serr_q;
    assign bus.start_glitch = gl_q;
endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed bench for uart_rx_gen2: frames driven bit by bit, pulses tallied by a monitor.
module tb_uart_rx_gen2;
    localparam int DW = 9;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_gen2_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

    uart_rx_gen2 #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int dv_n = 0, perr_n = 0, serr_n = 0, gl_n = 0, both_n = 0;
    logic [DW-1:0] pd_log [16];

    always @(negedge CLK) begin
        if (bus.Data_Valid) begin
            pd_log[4'(dv_n)] <= bus.P_DATA;
            dv_n <= dv_n + 1;
        end
        if (bus.par_err)                 perr_n <= perr_n + 1;
        if (bus.stp_err)                 serr_n <= serr_n + 1;
        if (bus.start_glitch)            gl_n   <= gl_n + 1;
        if (bus.par_err && bus.stp_err)  both_n <= both_n + 1;
    end

    int passes = 0, fails = 0, total = 0;
    int b_dv, b_perr, b_serr, b_gl, b_both;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic snap();
        b_dv = dv_n; b_perr = perr_n; b_serr = serr_n; b_gl = gl_n; b_both = both_n;
    endtask

    task automatic cfg(input logic pe, input logic pt, input logic s2,
                       input logic [3:0] len, input logic [5:0] ps);
        bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.STOP2 = s2;
        bus.DATA_LEN = len; bus.prescale = ps;
    endtask

    // gl: cycle offset inside the bit where the line is inverted for one CLK (-1 = none)
    task automatic send_bit(input logic b, input int presc, input int gl);
        for (int c = 0; c < presc; c++) begin
            bus.S_RX_IN = (c == gl) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input int pbit,
                              input int nstop, input int presc, input logic stop_val,
                              input int gl_bit, input bit mutate);
        logic [8:0] d;
        d = data;
        send_bit(1'b0, presc, -1);
        if (mutate) cfg(1'b1, 1'b1, 1'b1, 4'd5, 6'd8);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[0], presc, (i == gl_bit) ? presc / 2 : -1);
            d = d >> 1;
        end
        if (pbit >= 0) send_bit(pbit != 0, presc, -1);
        for (int i = 0; i < nstop; i++) send_bit(stop_val, presc, -1);
        bus.S_RX_IN = 1'b1;
    endtask

    initial begin
        bus.S_RX_IN = 1'b1;
        cfg(1'b0, 1'b0, 1'b0, 4'd8, 6'd16);
        tick(5);
        check("rst_pdata", 32'(bus.P_DATA), 0);
        check("rst_pulses", 32'({bus.Data_Valid, bus.par_err, bus.stp_err, bus.start_glitch}), 0);
        RST = 1'b1;
        tick(20);
        check("idle_no_pulse", 32'(dv_n + perr_n + serr_n + gl_n), 0);

        // 8N1 0xA5, config scrambled mid-frame must be ignored
        snap();
        send_frame(9'h0A5, 8, -1, 1, 16, 1'b1, -1, 1'b1);
        cfg(1'b0, 1'b0, 1'b0, 4'd8, 6'd16);
        tick(10);
        check("a5_dv", 32'(dv_n - b_dv), 1);
        check("a5_pdata", 32'(bus.P_DATA), 32'h0A5);
        check("a5_err", 32'(perr_n + serr_n + gl_n - b_perr - b_serr - b_gl), 0);

        // 7E2 0x55 with wrong parity bit
        snap();
        cfg(1'b1, 1'b0, 1'b1, 4'd7, 6'd8);
        send_frame(9'h055, 7, 1, 2, 8, 1'b1, -1, 1'b0);
        tick(10);
        check("par_perr", 32'(perr_n - b_perr), 1);
        check("par_dv", 32'(dv_n - b_dv), 0);
        check("par_serr", 32'(serr_n - b_serr), 0);
        check("par_hold", 32'(bus.P_DATA), 32'h0A5);

        // 3-CLK low pulse while idle
        snap();
        cfg(1'b0, 1'b0, 1'b0, 4'd8, 6'd16);
        bus.S_RX_IN = 1'b0;
        tick(3);
        bus.S_RX_IN = 1'b1;
        tick(40);
        check("gl_pulse", 32'(gl_n - b_gl), 1);
        check("gl_dv", 32'(dv_n - b_dv), 0);
        check("gl_err", 32'(perr_n + serr_n - b_perr - b_serr), 0);

        // back-to-back 9O1 frames at prescale 32
        snap();
        cfg(1'b1, 1'b1, 1'b0, 4'd9, 6'd32);
        send_frame(9'h000, 9, 1, 1, 32, 1'b1, -1, 1'b0);
        send_frame(9'h1FF, 9, 0, 1, 32, 1'b1, -1, 1'b0);
        tick(10);
        check("b2b_dv", 32'(dv_n - b_dv), 2);
        check("b2b_first", 32'(pd_log[4'(b_dv)]), 32'h000);
        check("b2b_second", 32'(pd_log[4'(b_dv + 1)]), 32'h1FF);
        check("b2b_err", 32'(perr_n + serr_n + gl_n - b_perr - b_serr - b_gl), 0);

        // single-sample glitch in bit 2 centre
        snap();
        cfg(1'b0, 1'b0, 1'b0, 4'd8, 6'd16);
        send_frame(9'h03C, 8, -1, 1, 16, 1'b1, 2, 1'b0);
        tick(10);
        check("vote_dv", 32'(dv_n - b_dv), 1);
        check("vote_pdata", 32'(bus.P_DATA), 32'h03C);

        // parity and stop error together
        snap();
        cfg(1'b1, 1'b0, 1'b0, 4'd8, 6'd16);
        send_frame(9'h001, 8, 0, 1, 16, 1'b0, -1, 1'b0);
        tick(10);
        check("both_perr", 32'(perr_n - b_perr), 1);
        check("both_serr", 32'(serr_n - b_serr), 1);
        check("both_same", 32'(both_n - b_both), 1);
        check("both_dv", 32'(dv_n - b_dv), 0);
        check("both_hold", 32'(bus.P_DATA), 32'h03C);

        // break with odd parity enabled
        snap();
        cfg(1'b1, 1'b1, 1'b0, 4'd8, 6'd16);
        bus.S_RX_IN = 1'b0;
        tick(16 * 14);
        check("brk_serr", 32'(serr_n - b_serr), 1);
        check("brk_perr", 32'(perr_n - b_perr), 0);
        check("brk_dv_gl", 32'(dv_n + gl_n - b_dv - b_gl), 0);
        tick(16 * 10);
        check("brk_wait", 32'(serr_n + perr_n + dv_n - b_serr - b_perr - b_dv), 1);
        bus.S_RX_IN = 1'b1;
        tick(20);

        // DATA_LEN 3 -> 5, prescale 20 -> 16
        snap();
        cfg(1'b0, 1'b0, 1'b0, 4'd3, 6'd20);
        send_frame(9'h01B, 5, -1, 1, 16, 1'b1, -1, 1'b0);
        tick(10);
        check("clamp_dv", 32'(dv_n - b_dv), 1);
        check("clamp_pdata", 32'(bus.P_DATA), 32'h01B);

        // reset in DATA of 0x3C, then 0xC3
        snap();
        cfg(1'b0, 1'b0, 1'b0, 4'd8, 6'd16);
        send_bit(1'b0, 16, -1);
        send_bit(1'b0, 16, -1);
        send_bit(1'b0, 16, -1);
        send_bit(1'b1, 16, -1);
        RST = 1'b0;
        bus.S_RX_IN = 1'b1;
        tick(4);
        RST = 1'b1;
        tick(40);
        check("abort_none", 32'(dv_n + perr_n + serr_n + gl_n - b_dv - b_perr - b_serr - b_gl), 0);
        check("abort_pdata", 32'(bus.P_DATA), 0);
        send_frame(9'h0C3, 8, -1, 1, 16, 1'b1, -1, 1'b0);
        tick(10);
        check("resume_dv", 32'(dv_n - b_dv), 1);
        check("resume_pdata", 32'(bus.P_DATA), 32'h0C3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
